gcd_controller: RTL and testbench

Control FSM that drives the GCD datapath: it accepts an operand pair over a valid/ready handshake, sequences the datapath's load/subtract/store strobes from its `a_eq_b`/`a_gt_b` status, and returns the result-ready indication over a second valid/ready handshake. It also flags zero operands and iteration-limit overruns as errors. It sits beside the datapath inside the GCD top level. Operand buses go to both blocks; the datapath's `res` is the result payload qualified by this block's `out_valid`.

---
 rtl/gcd_pkg.sv | 20 ++
 rtl/gcd_controller.sv | 124 ++++++++++++
 tb/tb_gcd_controller.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD controller.
package gcd_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Default limit on subtract steps before a job is aborted.
    localparam int DEFAULT_MAX_ITER = 1024;

    // Width of a counter that must represent 0..max_iter inclusive.
    function automatic int cnt_width(input int max_iter);
        return $clog2(max_iter + 1);
    endfunction

endpackage

// File: rtl/gcd_controller.sv
// Control FSM for the subtractive GCD datapath: accepts an operand pair,
// sequences load/subtract/store strobes from the datapath status, and
// reports the result (or an abort) over an output handshake.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_ITER = DEFAULT_MAX_ITER
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [N-1:0]                      A_in,
    input  logic [N-1:0]                      B_in,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              a_eq_b,
    input  logic                              a_gt_b,
    output logic                              sel_A,
    output logic                              sel_B,
    output logic                              wr_A,
    output logic                              wr_B,
    output logic                              wr_res,
    output logic                              out_valid,
    output logic                              out_err,
    input  logic                              out_ready,
    output logic                              busy,
    output logic [cnt_width(MAX_ITER)-1:0]    iter_cnt
);

    localparam int CW = cnt_width(MAX_ITER);
    localparam logic [CW-1:0] ITER_LIMIT = CW'(MAX_ITER);

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   iter_cnt_reg;
    logic [CW-1:0]   iter_cnt_next;
    logic            operand_zero;

    assign operand_zero = (A_in == '0) || (B_in == '0);
    assign iter_cnt     = iter_cnt_reg;

    // State and iteration counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            iter_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            iter_cnt_reg <= iter_cnt_next;
        end
    end

    // Next-state, counter update and Mealy/Moore strobe decode.
    always_comb begin
        state_next    = state_reg;
        iter_cnt_next = iter_cnt_reg;
        in_ready      = 1'b0;
        sel_A         = 1'b0;
        sel_B         = 1'b0;
        wr_A          = 1'b0;
        wr_B          = 1'b0;
        wr_res        = 1'b0;
        out_valid     = 1'b0;
        out_err       = 1'b0;
        busy          = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // Every accept starts a new job, so the step count restarts.
                    iter_cnt_next = '0;
                    if (operand_zero) begin
                        state_next = ERR;
                    end else begin
                        // Load both operand registers in the accept cycle.
                        wr_A       = 1'b1;
                        wr_B       = 1'b1;
                        state_next = CALC;
                    end
                end
            end

            CALC: begin
                busy = 1'b1;
                if (a_eq_b) begin
                    wr_res     = 1'b1;
                    state_next = DONE;
                end else if (iter_cnt_reg == ITER_LIMIT) begin
                    // Step budget exhausted: abort without touching the datapath.
                    state_next = ERR;
                end else if (a_gt_b) begin
                    wr_A          = 1'b1;
                    sel_A         = 1'b1;
                    iter_cnt_next = iter_cnt_reg + CW'(1);
                end else begin
                    wr_B          = 1'b1;
                    sel_B         = 1'b1;
                    iter_cnt_next = iter_cnt_reg + CW'(1);
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            ERR: begin
                out_valid = 1'b1;
                out_err   = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
// Self-checking bench for gcd_controller. Two instances are exercised: one
// with the default step limit and one with a limit of 4. Each has a small
// behavioural datapath beside it; expectations come from a Euclid-based
// reference model.
module tb_gcd_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] a_in [2];
    logic [31:0] b_in [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic        a_eq_b [2];
    logic        a_gt_b [2];
    logic        sel_a [2];
    logic        sel_b [2];
    logic        wr_a [2];
    logic        wr_b [2];
    logic        wr_res [2];
    logic        out_valid [2];
    logic        out_err [2];
    logic        out_ready [2];
    logic        busy [2];
    logic [10:0] iter0;
    logic [2:0]  iter1;

    logic [31:0] da [2];
    logic [31:0] db [2];
    logic [31:0] dres [2];

    gcd_controller #(.N(32), .MAX_ITER(1024)) dut (
        .clk(clk), .rst(rst), .A_in(a_in[0]), .B_in(b_in[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a_eq_b(a_eq_b[0]), .a_gt_b(a_gt_b[0]),
        .sel_A(sel_a[0]), .sel_B(sel_b[0]), .wr_A(wr_a[0]), .wr_B(wr_b[0]),
        .wr_res(wr_res[0]), .out_valid(out_valid[0]), .out_err(out_err[0]),
        .out_ready(out_ready[0]), .busy(busy[0]), .iter_cnt(iter0)
    );

    gcd_controller #(.N(32), .MAX_ITER(4)) dut_lim (
        .clk(clk), .rst(rst), .A_in(a_in[1]), .B_in(b_in[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a_eq_b(a_eq_b[1]), .a_gt_b(a_gt_b[1]),
        .sel_A(sel_a[1]), .sel_B(sel_b[1]), .wr_A(wr_a[1]), .wr_B(wr_b[1]),
        .wr_res(wr_res[1]), .out_valid(out_valid[1]), .out_err(out_err[1]),
        .out_ready(out_ready[1]), .busy(busy[1]), .iter_cnt(iter1)
    );

    // Behavioural datapath for each instance.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                da[i]   <= '0;
                db[i]   <= '0;
                dres[i] <= '0;
            end else begin
                if (wr_a[i])   da[i]   <= sel_a[i] ? da[i] - db[i] : a_in[i];
                if (wr_b[i])   db[i]   <= sel_b[i] ? db[i] - da[i] : b_in[i];
                if (wr_res[i]) dres[i] <= da[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            a_eq_b[i] = (da[i] == db[i]);
            a_gt_b[i] = (da[i] > db[i]);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Observations from the most recent run_job.
    int          obs_cycle;
    logic        obs_err;
    logic [31:0] obs_res;
    int          obs_iter;
    int          obs_sub;
    int          obs_wr;
    int          obs_multi;
    logic        obs_acc_ready;
    logic [2:0]  obs_log [0:7];

    function automatic int cur_iter(input int idx);
        if (idx == 0) return int'(iter0);
        return int'(iter1);
    endfunction

    function automatic logic [2:0] strobes(input int idx);
        return {wr_res[idx], wr_b[idx], wr_a[idx]};
    endfunction

    // Reference: subtractive step count is the sum of Euclid quotients minus one.
    function automatic void ref_job(input int unsigned a, input int unsigned b,
                                    input int maxi, output logic err,
                                    output int cyc, output int unsigned res,
                                    output int iter, output int sub);
        int unsigned x, y, t;
        int k;
        if (a == 0 || b == 0) begin
            err = 1'b1; cyc = 1; res = 0; iter = -1; sub = 0;
            return;
        end
        x = a; y = b; k = 0;
        while (y != 0) begin
            k += int'(x / y);
            t = x % y;
            x = y;
            y = t;
        end
        k -= 1;
        res = x;
        if (k > maxi) begin
            err = 1'b1; cyc = 2 + maxi; iter = maxi; sub = maxi;
        end else begin
            err = 1'b0; cyc = 2 + k; iter = k; sub = k;
        end
    endfunction

    // Offer one operand pair and watch the controller until out_valid.
    task automatic run_job(input int idx, input logic [31:0] a, input logic [31:0] b);
        logic [2:0] s;
        obs_cycle = -1; obs_err = 1'bx; obs_res = 'x; obs_iter = -1;
        obs_sub = 0; obs_wr = 0; obs_multi = 0;
        for (int i = 0; i < 8; i++) obs_log[i] = 3'b000;
        @(negedge clk);
        a_in[idx] = a; b_in[idx] = b; in_valid[idx] = 1'b1;
        #1;
        obs_acc_ready = in_ready[idx];
        obs_log[0] = strobes(idx);
        for (int c = 1; c < 3000; c++) begin
            @(negedge clk);
            in_valid[idx] = 1'b0;
            #1;
            s = strobes(idx);
            if (c < 8) obs_log[c] = s;
            if ($countones(s) > 1) obs_multi++;
            obs_sub += int'(s[0]) + int'(s[1]);
            obs_wr  += int'(s[2]);
            if (out_valid[idx]) begin
                obs_cycle = c;
                obs_err   = out_err[idx];
                obs_res   = dres[idx];
                obs_iter  = cur_iter(idx);
                break;
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({in_ready[i], out_valid[i], out_err[i], busy[i], strobes(i), sel_a[i], sel_b[i]} !== 9'b1_0000_0000) begin
                $display("FAIL reset_outputs[%0d]: got rdy=%b ov=%b oe=%b busy=%b str=%b sel=%b%b, want rdy=1 rest 0",
                         i, in_ready[i], out_valid[i], out_err[i], busy[i], strobes(i), sel_a[i], sel_b[i]);
            end else n_pass++;
            n_checks++;
            if (cur_iter(i) !== 0) $display("FAIL reset_iter[%0d]: got %0d want 0", i, cur_iter(i));
            else n_pass++;
        end
        $display("reset: outputs checked on both instances");
    endtask

    task automatic test_normal();
        run_job(0, 12, 8);
        $display("normal: A=12 B=8 cyc=%0d err=%b res=%0d iter=%0d", obs_cycle, obs_err, obs_res, obs_iter);
        n_checks++;
        if (obs_acc_ready !== 1'b1) $display("FAIL normal_in_ready: got %b want 1", obs_acc_ready);
        else n_pass++;
        n_checks++;
        if ({obs_log[0], obs_log[1], obs_log[2], obs_log[3]} !== {3'b011, 3'b001, 3'b010, 3'b100})
            $display("FAIL normal_strobes: got %b %b %b %b want 011 001 010 100",
                     obs_log[0], obs_log[1], obs_log[2], obs_log[3]);
        else n_pass++;
        n_checks++;
        if (obs_cycle !== 4) $display("FAIL normal_latency: got %0d want 4", obs_cycle);
        else n_pass++;
        n_checks++;
        if ({obs_err, obs_res} !== {1'b0, 32'd4}) $display("FAIL normal_result: got err=%b res=%0d want err=0 res=4", obs_err, obs_res);
        else n_pass++;
        n_checks++;
        if (obs_iter !== 2) $display("FAIL normal_iter: got %0d want 2", obs_iter);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready[0], out_valid[0]} !== 2'b10) $display("FAIL normal_return_idle: got rdy=%b ov=%b want 1 0", in_ready[0], out_valid[0]);
        else n_pass++;
    endtask

    task automatic test_equal();
        run_job(0, 7, 7);
        $display("equal: A=7 B=7 cyc=%0d err=%b res=%0d iter=%0d", obs_cycle, obs_err, obs_res, obs_iter);
        n_checks++;
        if (obs_log[1] !== 3'b100) $display("FAIL equal_wr_res: got strobes %b in cycle 1 want 100", obs_log[1]);
        else n_pass++;
        n_checks++;
        if ({obs_cycle, obs_iter} !== {32'sd2, 32'sd0}) $display("FAIL equal_timing: got cyc=%0d iter=%0d want 2 0", obs_cycle, obs_iter);
        else n_pass++;
        n_checks++;
        if ({obs_err, obs_res} !== {1'b0, 32'd7}) $display("FAIL equal_result: got err=%b res=%0d want 0 7", obs_err, obs_res);
        else n_pass++;
    endtask

    task automatic test_zero();
        logic [31:0] za [2] = '{32'd0, 32'd5};
        logic [31:0] zb [2] = '{32'd5, 32'd0};
        for (int i = 0; i < 2; i++) begin
            run_job(0, za[i], zb[i]);
            $display("zero: A=%0d B=%0d cyc=%0d err=%b", za[i], zb[i], obs_cycle, obs_err);
            n_checks++;
            if ({obs_cycle, obs_err} !== {32'sd1, 1'b1}) $display("FAIL zero_err: got cyc=%0d err=%b want 1 1", obs_cycle, obs_err);
            else n_pass++;
            n_checks++;
            if ({obs_log[0], obs_log[1]} !== 6'b0) $display("FAIL zero_strobes: got %b %b want 000 000", obs_log[0], obs_log[1]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        run_job(1, 100, 1);
        $display("timeout: A=100 B=1 cyc=%0d err=%b iter=%0d sub=%0d wr_res=%0d", obs_cycle, obs_err, obs_iter, obs_sub, obs_wr);
        n_checks++;
        if ({obs_cycle, obs_err} !== {32'sd6, 1'b1}) $display("FAIL timeout_err: got cyc=%0d err=%b want 6 1", obs_cycle, obs_err);
        else n_pass++;
        n_checks++;
        if ({obs_iter, obs_sub, obs_wr} !== {32'sd4, 32'sd4, 32'sd0})
            $display("FAIL timeout_counts: got iter=%0d sub=%0d wr_res=%0d want 4 4 0", obs_iter, obs_sub, obs_wr);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        out_ready[0] = 1'b0;
        run_job(0, 12, 8);
        $display("backpressure: job done cyc=%0d res=%0d, holding out_ready=0", obs_cycle, obs_res);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 3) begin
                a_in[0] = 32'd3; b_in[0] = 32'd3; in_valid[0] = 1'b1;
            end
            #1;
            n_checks++;
            if ({out_valid[0], out_err[0], in_ready[0], strobes(0), dres[0], cur_iter(0)} !== {3'b100, 3'b000, 32'd4, 32'sd2})
                $display("FAIL backpressure_hold[%0d]: got ov=%b oe=%b rdy=%b str=%b res=%0d iter=%0d want 1 0 0 000 4 2",
                         i, out_valid[0], out_err[0], in_ready[0], strobes(0), dres[0], cur_iter(0));
            else n_pass++;
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if ({in_ready[0], out_valid[0]} !== 2'b10) $display("FAIL backpressure_release: got rdy=%b ov=%b want 1 0", in_ready[0], out_valid[0]);
        else n_pass++;
        run_job(0, 35, 21);
        $display("backpressure: follow-up A=35 B=21 cyc=%0d err=%b res=%0d", obs_cycle, obs_err, obs_res);
        n_checks++;
        if ({obs_cycle, obs_err, obs_res} !== {32'sd5, 1'b0, 32'd7})
            $display("FAIL backpressure_next_job: got cyc=%0d err=%b res=%0d want 5 0 7", obs_cycle, obs_err, obs_res);
        else n_pass++;
    endtask

    task automatic test_reset_mid_calc();
        @(negedge clk);
        a_in[0] = 32'd1000; b_in[0] = 32'd3; in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        n_checks++;
        if (busy[0] !== 1'b1) $display("FAIL midreset_busy: got %b want 1", busy[0]);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready[0], busy[0], out_valid[0], strobes(0), sel_a[0], sel_b[0]} !== 8'b1000_0000)
            $display("FAIL midreset_state: got rdy=%b busy=%b ov=%b str=%b sel=%b%b want 1 0 0 000 00",
                     in_ready[0], busy[0], out_valid[0], strobes(0), sel_a[0], sel_b[0]);
        else n_pass++;
        n_checks++;
        if (cur_iter(0) !== 0) $display("FAIL midreset_iter: got %0d want 0", cur_iter(0));
        else n_pass++;
        run_job(0, 1000, 3);
        $display("midreset: rerun A=1000 B=3 cyc=%0d err=%b res=%0d iter=%0d", obs_cycle, obs_err, obs_res, obs_iter);
        n_checks++;
        if ({obs_cycle, obs_err, obs_res, obs_iter} !== {32'sd337, 1'b0, 32'd1, 32'sd335})
            $display("FAIL midreset_rerun: got cyc=%0d err=%b res=%0d iter=%0d want 337 0 1 335",
                     obs_cycle, obs_err, obs_res, obs_iter);
        else n_pass++;
    endtask

    task automatic test_random();
        int unsigned a, b, e_res;
        logic e_err;
        int e_cyc, e_iter, e_sub, maxi;
        for (int n = 0; n < 24; n++) begin
            int idx = n % 2;
            maxi = (idx == 0) ? 1024 : 4;
            a = (idx == 0) ? $urandom_range(300, 1) : $urandom_range(20, 1);
            b = (idx == 0) ? $urandom_range(300, 1) : $urandom_range(20, 1);
            if ($urandom_range(7, 0) == 0) a = 0;
            ref_job(a, b, maxi, e_err, e_cyc, e_res, e_iter, e_sub);
            run_job(idx, a, b);
            $display("random[%0d]: inst=%0d A=%0d B=%0d cyc=%0d err=%b res=%0d iter=%0d",
                     n, idx, a, b, obs_cycle, obs_err, obs_res, obs_iter);
            n_checks++;
            if ({obs_cycle, obs_err} !== {e_cyc, e_err})
                $display("FAIL random_timing[%0d]: got cyc=%0d err=%b want %0d %b", n, obs_cycle, obs_err, e_cyc, e_err);
            else n_pass++;
            if (!e_err) begin
                n_checks++;
                if (obs_res !== e_res) $display("FAIL random_res[%0d]: got %0d want %0d", n, obs_res, e_res);
                else n_pass++;
            end
            if (e_iter >= 0) begin
                n_checks++;
                if ({obs_iter, obs_sub, obs_wr} !== {e_iter, e_sub, (e_err ? 0 : 1)})
                    $display("FAIL random_counts[%0d]: got iter=%0d sub=%0d wr_res=%0d want %0d %0d %0d",
                             n, obs_iter, obs_sub, obs_wr, e_iter, e_sub, e_err ? 0 : 1);
                else n_pass++;
            end
            n_checks++;
            if (obs_multi !== 0) $display("FAIL random_exclusive[%0d]: got %0d overlapping strobe cycles want 0", n, obs_multi);
            else n_pass++;
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            a_in[i] = '0; b_in[i] = '0; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        test_reset();
        test_normal();
        test_equal();
        test_zero();
        test_timeout();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
